// File: rtl/lu_pkg.sv
// Shared opcode constants and FSM state encoding for the logic-unit arbiter.
package lu_pkg;

  localparam logic [2:0] LU_AND     = 3'd0;
  localparam logic [2:0] LU_OR      = 3'd1;
  localparam logic [2:0] LU_NOT     = 3'd2;
  localparam logic [2:0] LU_NAND    = 3'd3;
  localparam logic [2:0] LU_NOR     = 3'd4;
  localparam logic [2:0] LU_XOR     = 3'd5;
  localparam logic [2:0] LU_XNOR    = 3'd6;
  localparam logic [2:0] LU_ILLEGAL = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

endpackage

// File: rtl/logic_unit.sv
// Combinational W-bit bitwise gate datapath; opcode 7 yields zero and flags an error.
module logic_unit
  import lu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         err
);

  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      LU_AND:  y = a & b;
      LU_OR:   y = a | b;
      LU_NOT:  y = ~a;
      LU_NAND: y = ~(a & b);
      LU_NOR:  y = ~(a | b);
      LU_XOR:  y = a ^ b;
      LU_XNOR: y = ~(a ^ b);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic_unit among NREQ requesters with a registered response.
// Optional LU_ARB_STATS_EN adds a saturating completed-op counter port op_count.
module logic_unit_arbiter
  import lu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [3*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0] req_a,
  input  logic [W*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_data,
  output logic [IDW-1:0]    rsp_id,
`ifdef LU_ARB_STATS_EN
  output logic [15:0]       op_count,
`endif
  output logic              rsp_err
);

  state_t         state, state_next;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] win;
  logic           found;
  logic           grant;
  logic [IDW:0]   pick;
  logic [2:0]     sel_op;
  logic [W-1:0]   sel_a, sel_b, lu_y;
  logic           lu_err;

  // Returns {found, index} of the first valid requester at or after ptr, wrapping.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                           input logic [IDW-1:0]  ptr);
    logic           hit;
    logic [IDW-1:0] idx;
    int             j;
    hit = 1'b0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!hit && valid[j]) begin
        hit = 1'b1;
        idx = IDW'(j);
      end
    end
    return {hit, idx};
  endfunction

  assign pick   = rr_pick(req_valid, rr_ptr);
  assign found  = pick[IDW];
  assign win    = pick[IDW-1:0];
  assign sel_op = req_op[3*int'(win) +: 3];
  assign sel_a  = req_a[W*int'(win) +: W];
  assign sel_b  = req_b[W*int'(win) +: W];

  logic_unit #(.W(W)) u_lu (
    .op  (sel_op),
    .a   (sel_a),
    .b   (sel_b),
    .y   (lu_y),
    .err (lu_err)
  );

  always_comb begin
    state_next = state;
    req_ready  = '0;
    grant      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (found) begin
          req_ready  = NREQ'(1) << win;
          grant      = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign rsp_valid = (state == ST_RESP);

  // Response fields only load on a grant, so they hold steady under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_next;
      if (grant) begin
        rsp_data <= lu_y;
        rsp_err  <= lu_err;
        rsp_id   <= win;
        rr_ptr   <= (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
      end
    end
  end

`ifdef LU_ARB_STATS_EN
  logic [15:0] op_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else if (rsp_valid && rsp_ready && op_count_q != 16'hFFFF) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

- Shares one W-bit combinational logic unit (AND/OR/NOT/NAND/NOR/XOR/XNOR) between NREQ requesters.
- Arbitration is round-robin; each requester uses a valid/ready handshake.
- Each result is registered and returned on a single response channel, tagged with the winning requester's index.
- Sits between multiple command sources (switch/UART decoders, test sequencers) and the shared gate datapath.

## Interface

**Parameters**
- NREQ, 4: number of requesters (2..8).
- W, 8: operand and result width.
- IDW, 2: response tag width; must equal clog2(NREQ).

**Ports**
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset, asynchronous assert, active-low.
- req_valid, input, NREQ: request present, one bit per requester.
- req_ready, output, NREQ: grant/accept, one-hot or zero.
- req_op, input, 3*NREQ: opcode of requester i at [3i+:3].
- req_a, input, W*NREQ: operand A of requester i at [Wi+:W].
- req_b, input, W*NREQ: operand B of requester i at [Wi+:W].
- rsp_valid, output, 1: result available.
- rsp_ready, input, 1: consumer accepts the result.
- rsp_data, output, W: result.
- rsp_id, output, IDW: index of the requester served.
- rsp_err, output, 1: opcode was illegal.
- op_count, output, 16: completed-op counter (present only with LU_ARB_STATS_EN).

## Operation

**Opcodes**
- 0 AND, 1 OR, 2 NOT (~a, b ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR.
- 7 is illegal: result is 0 and rsp_err=1.
- All operations are bitwise over W bits; no carries or width growth.

**State machine: IDLE, RESP**
- IDLE:
  - Winner = first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NREQ.
  - req_ready[winner]=1, combinationally.
  - On that cycle's edge: rsp_data/rsp_err latch the logic-unit result, rsp_id latches the winner, rsp_valid becomes 1, rr_ptr becomes (winner+1) mod NREQ, state becomes RESP.
  - If no req_valid bit is set, req_ready=0 and state stays IDLE.
- RESP:
  - req_ready=0 for all requesters.
  - rsp_data, rsp_id and rsp_err are held stable while rsp_valid=1 and rsp_ready=0.
  - When rsp_ready=1: rsp_valid clears and state returns to IDLE. No new grant is issued in that same cycle.

**Rules**
- rr_ptr changes only on an accepted request.
- A requester may drop req_valid before being granted; no side effects.
- Simultaneous requests are resolved only by rr_ptr.

## Timing

**Reset values**
- State=IDLE, rr_ptr=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, op_count=0, req_ready=0.

**Latency and throughput**
- Latency is 1 cycle: a request accepted at edge N presents rsp_valid=1 after edge N.
- Peak throughput is 1 op per 2 cycles, reached when rsp_ready is held at 1.

**Reset during RESP**
- rsp_valid clears immediately, asynchronously.
- The pending result is discarded and not counted.

**Output timing**
- req_ready depends combinationally on req_valid and state only, never on rsp_ready.

## Configuration

**LU_ARB_STATS_EN**
- Defined:
  - op_count port exists.
  - op_count increments on each response handshake (rsp_valid & rsp_ready), illegal ops included.
  - op_count saturates at 16'hFFFF and does not wrap.
  - It is cleared only by reset.
- Undefined: the op_count port and its register are absent. All other behaviour is identical.

## Structure

**Package lu_pkg**
- Opcode constants: LU_AND=3'd0 … LU_XNOR=3'd6, LU_ILLEGAL=3'd7.
- State encoding: ST_IDLE, ST_RESP.

**Sub-module logic_unit**
- Purely combinational: op, a, b -> y, err.
- Instantiated once.
- Reuses the same bitwise gate equations as the existing gate block, widened to W.

**Arbiter**
- Round-robin search is a function inside logic_unit_arbiter; no separate module.

## Test plan

1. Reset release, no requests -> all outputs 0, req_ready=0, state IDLE for 10 cycles.
2. Single requester 2, op=5, a=8'hF0, b=8'h3C, rsp_ready=1 -> req_ready=4'b0100 one cycle; next cycle rsp_valid=1, rsp_data=8'hCC, rsp_id=2, rsp_err=0.
3. All four req_valid held, rsp_ready=1 -> grant order 0,1,2,3,0, one grant every 2 cycles; each rsp_id matches its grant.
4. Backpressure: rsp_ready=0 for 5 cycles after a response -> rsp_data/rsp_id stable, no req_ready asserted; rsp_ready=1 -> rsp_valid drops next edge.
5. op=7, a=8'hFF -> rsp_data=0, rsp_err=1. Also op=2, a=8'hA5 -> rsp_data=8'h5A.
6. rst_n low while in RESP -> rsp_valid=0 immediately. With LU_ARB_STATS_EN: op_count=0 after reset, equals 3 after three handshakes, and stays 16'hFFFF when forced near saturation.
